// File: rtl/eth_pcs_pkg.sv
// Shared 64b/66b PCS definitions: scrambler polynomial, sync header codes,
// the sideband bundle that travels with each descrambled word, and helpers.
package eth_pcs_pkg;

    // Self-synchronous scrambler x^58 + x^39 + 1.
    // Tap indices are positions in the 58-bit history register.
    localparam int SCR_LEN   = 58;
    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;

    typedef logic [SCR_LEN-1:0] scr_state_t;

    localparam scr_state_t SCR_INIT = '1;

    // Legal 66b sync headers; 00 and 11 are illegal.
    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Width of the saturating illegal-header counter.
    localparam int HDR_CNT_W = 16;

    // Per-word sideband carried next to the payload through the output stages.
    typedef struct packed {
        logic       hdr_err;
        logic       settled;
        logic       header_valid;
        logic [1:0] header;
    } sideband_t;

    // Words needed before the whole scrambler history comes from real input.
    function automatic int scr_settle_words(input int width);
        return (SCR_LEN + width - 1) / width;
    endfunction

    // True when a sync header is neither the data nor the control code.
    function automatic logic sync_hdr_illegal(input logic [1:0] hdr);
        return (hdr != SYNC_DATA) && (hdr != SYNC_CTRL);
    endfunction

endpackage

// File: rtl/eth_descrambler_if.sv
// Stream bundle between the block-lock stage, the descrambler and the decoder.
//
// Handshake (both directions): a beat moves on a rising clock edge where
// valid and ready are both high. Once valid is raised it stays high, with its
// payload unchanged, until that edge. Ready never depends combinationally on
// valid on the same side.
interface eth_descrambler_if #(
    parameter int DATA_WIDTH = 32
);

    // Upstream side (into the descrambler)
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic [1:0]            i_header;
    logic                  i_header_valid;

    // Downstream side (out of the descrambler)
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic [1:0]            o_header;
    logic                  o_header_valid;
    logic                  o_settled;
    logic                  o_hdr_err;

    // Descrambler view
    modport slave (
        input  i_valid, i_data, i_header, i_header_valid, i_ready,
        output o_ready, o_valid, o_data, o_header, o_header_valid,
               o_settled, o_hdr_err
    );

    // Environment view: drives upstream beats and downstream ready
    modport master (
        output i_valid, i_data, i_header, i_header_valid, i_ready,
        input  o_ready, o_valid, o_data, o_header, o_header_valid,
               o_settled, o_hdr_err
    );

endinterface

// File: rtl/eth_skid_buffer.sv
// Two-entry output pipeline: an output register plus one skid register.
// o_ready is a pure register (not skid full), so there is no combinational
// path from i_ready to o_ready. The skid always drains before a new beat is
// taken, which keeps order. Flush empties both entries.
module eth_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             out_free;

    // Output register can take a new word when empty or transferring now.
    assign out_free = !out_valid_q || i_ready;

    // Move beats: skid -> output first, otherwise input -> output or skid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (i_flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            if (out_free) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                skid_valid_q <= 1'b0;
            end
        end else if (i_valid) begin
            if (out_free) begin
                out_valid_q <= 1'b1;
                out_data_q  <= i_data;
            end else begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= i_data;
            end
        end else if (i_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign o_ready = !skid_valid_q;
    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;

endmodule

// File: rtl/eth_descrambler.sv
// Receive-side 64b/66b descrambler (x^58 + x^39 + 1).
// The descrambling network is combinational on the incoming word; the
// history register, settle counter and header-error counter live here and
// advance only when a beat is accepted. Results go through a skid buffer
// together with the sync header, the settled flag and the header-error flag.
module eth_descrambler
    import eth_pcs_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_flush,
    input  logic                 descrambler_bypass,
    input  logic                 i_hdr_err_clear,
    output logic [HDR_CNT_W-1:0] o_hdr_err_count,
    eth_descrambler_if.slave     bus
);

    // Settle counter saturates at the number of words that fill the history.
    localparam int SETTLE_WORDS = scr_settle_words(DATA_WIDTH);
    localparam int CNT_W        = (SETTLE_WORDS > 1) ? $clog2(SETTLE_WORDS + 1) : 1;
    localparam int BUNDLE_W     = DATA_WIDTH + $bits(sideband_t);

    localparam logic [CNT_W-1:0]     SETTLE_CNT = CNT_W'(SETTLE_WORDS);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
    localparam logic [HDR_CNT_W-1:0] HDR_ONE    = HDR_CNT_W'(1);
    localparam logic [HDR_CNT_W-1:0] HDR_MAX    = '1;

    scr_state_t            scr_q;
    scr_state_t            scr_d;
    logic [CNT_W-1:0]      settle_cnt_q;
    logic [HDR_CNT_W-1:0]  hdr_cnt_q;

    logic [DATA_WIDTH-1:0] desc_data;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    sideband_t             sb_in;
    sideband_t             sb_out;
    logic [BUNDLE_W-1:0]   bundle_out;

    logic                  skid_in_valid;
    logic                  skid_ready;
    logic                  out_valid;
    logic                  push;
    logic                  hdr_bad;

    // A beat offered during flush still sees o_ready, but it is discarded.
    assign skid_in_valid = bus.i_valid && !i_flush;
    assign push          = skid_in_valid && skid_ready;
    assign hdr_bad       = bus.i_header_valid && sync_hdr_illegal(bus.i_header);

    // Bit-serial descramble, MSB first; the history shifts in received bits.
    always_comb begin
        scr_state_t s;
        s         = scr_q;
        desc_data = '0;
        for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
            desc_data[b] = bus.i_data[b] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
            s            = {s[SCR_LEN-2:0], bus.i_data[b]};
        end
        scr_d = s;
    end

    // Select payload and assemble the sideband for the incoming word.
    always_comb begin
        data_in             = descrambler_bypass ? bus.i_data : desc_data;
        sb_in.hdr_err       = hdr_bad;
        sb_in.settled       = (settle_cnt_q == SETTLE_CNT);
        sb_in.header_valid  = bus.i_header_valid;
        sb_in.header        = bus.i_header;
    end

    // History register: advances on every kept beat, bypassed or not.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scr_q <= SCR_INIT;
        end else if (push) begin
            scr_q <= scr_d;
        end
    end

    // Settle counter: words since reset or flush, saturating.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            settle_cnt_q <= '0;
        end else if (i_flush) begin
            settle_cnt_q <= '0;
        end else if (push && (settle_cnt_q != SETTLE_CNT)) begin
            settle_cnt_q <= settle_cnt_q + CNT_ONE;
        end
    end

    // Illegal-header counter: saturating; clear wins but still counts this beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hdr_cnt_q <= '0;
        end else if (i_hdr_err_clear) begin
            hdr_cnt_q <= (push && hdr_bad) ? HDR_ONE : '0;
        end else if (push && hdr_bad && (hdr_cnt_q != HDR_MAX)) begin
            hdr_cnt_q <= hdr_cnt_q + HDR_ONE;
        end
    end

    eth_skid_buffer #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_valid (skid_in_valid),
        .o_ready (skid_ready),
        .i_data  ({sb_in, data_in}),
        .o_valid (out_valid),
        .i_ready (bus.i_ready),
        .o_data  (bundle_out)
    );

    assign {sb_out, data_out} = bundle_out;

    assign bus.o_ready        = skid_ready;
    assign bus.o_valid        = out_valid;
    assign bus.o_data         = data_out;
    assign bus.o_header       = sb_out.header;
    assign bus.o_header_valid = sb_out.header_valid;
    assign bus.o_settled      = sb_out.settled;
    assign bus.o_hdr_err      = out_valid && sb_out.hdr_err;
    assign o_hdr_err_count    = hdr_cnt_q;

endmodule

// File: tb/tb_eth_descrambler.sv
// Bench for eth_descrambler (DATA_WIDTH=32). A transmit scrambler and a
// receive reference are kept as bit-history queues; each accepted beat pushes
// {hdr_err, settled, header_valid, header, data} into exp_q, and every output
// transfer is compared against the queue front.
module tb_eth_descrambler;

    localparam int W      = 32;
    localparam int EW     = W + 5;
    localparam int SETTLE = 2;

    logic        i_clk;
    logic        i_rst;
    logic        i_flush;
    logic        descrambler_bypass;
    logic        i_hdr_err_clear;
    logic [15:0] o_hdr_err_count;

    eth_descrambler_if #(.DATA_WIDTH(W)) bus ();

    eth_descrambler #(.DATA_WIDTH(W)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_flush            (i_flush),
        .descrambler_bypass (descrambler_bypass),
        .i_hdr_err_clear    (i_hdr_err_clear),
        .o_hdr_err_count    (o_hdr_err_count),
        .bus                (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model state
    bit            tx_hist[$];
    bit            rx_hist[$];
    logic [EW-1:0] exp_q[$];
    int            words_since;
    int            hdr_cnt_model;
    logic [W-1:0]  cur_payload;

    // Stimulus controls
    bit   ready_rand = 1'b0;
    logic ready_fixed = 1'b1;
    bit   chk_ordy = 1'b0;

    // ---------------- clock / reset block ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        forever begin
            @(posedge i_clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got no finish by 1000000 ns, required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog expired");
    end

    // Downstream ready driver
    initial begin
        bus.i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #2;
            if (ready_rand) bus.i_ready = ($urandom_range(0, 1) == 1);
            else            bus.i_ready = ready_fixed;
        end
    end

    // ---------------- reference model ----------------
    task automatic tx_scramble(input logic [W-1:0] p, output logic [W-1:0] sc);
        for (int b = W - 1; b >= 0; b--) begin
            sc[b] = p[b] ^ tx_hist[tx_hist.size() - 39] ^ tx_hist[tx_hist.size() - 58];
            tx_hist.push_back(sc[b]);
            void'(tx_hist.pop_front());
        end
    endtask

    task automatic rx_model(input logic [W-1:0] rx, output logic [W-1:0] d);
        for (int b = W - 1; b >= 0; b--) begin
            d[b] = rx[b] ^ rx_hist[rx_hist.size() - 39] ^ rx_hist[rx_hist.size() - 58];
            rx_hist.push_back(rx[b]);
            void'(rx_hist.pop_front());
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        rx_hist.delete();
        for (int i = 0; i < 58; i++) rx_hist.push_back(1'b1);
        words_since   = 0;
        hdr_cnt_model = 0;
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial begin : monitor
        logic [EW-1:0] e;
        logic [W-1:0]  d;
        logic [W-1:0]  exp_data;
        logic          settled;
        logic          err;
        logic          acc;
        int            ordy_run;
        ordy_run = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                ordy_run = 0;
            end else begin
                if (bus.o_valid && bus.i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL out_unexpected: got beat data %h, required no beat", bus.o_data);
                    end else begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (bus.o_data !== e[W-1:0]) begin
                            n_fail++;
                            $display("FAIL out_data: got %h, required %h", bus.o_data, e[W-1:0]);
                        end
                        n_cmp++;
                        if (bus.o_header !== e[W+1:W]) begin
                            n_fail++;
                            $display("FAIL out_header: got %b, required %b", bus.o_header, e[W+1:W]);
                        end
                        n_cmp++;
                        if (bus.o_header_valid !== e[W+2]) begin
                            n_fail++;
                            $display("FAIL out_header_valid: got %b, required %b", bus.o_header_valid, e[W+2]);
                        end
                        n_cmp++;
                        if (bus.o_settled !== e[W+3]) begin
                            n_fail++;
                            $display("FAIL out_settled: got %b, required %b", bus.o_settled, e[W+3]);
                        end
                        n_cmp++;
                        if (bus.o_hdr_err !== e[W+4]) begin
                            n_fail++;
                            $display("FAIL out_hdr_err: got %b, required %b", bus.o_hdr_err, e[W+4]);
                        end
                    end
                end
                if (chk_ordy) begin
                    if (bus.i_ready && !bus.o_ready) ordy_run++;
                    else ordy_run = 0;
                    n_cmp++;
                    if (ordy_run > 1) begin
                        n_fail++;
                        $display("FAIL ordy_stall: got %0d low cycles with i_ready, required at most 1", ordy_run);
                    end
                end
                acc = bus.i_valid && bus.o_ready && !i_flush;
                err = bus.i_header_valid && ((bus.i_header == 2'b00) || (bus.i_header == 2'b11));
                if (acc) begin
                    rx_model(bus.i_data, d);
                    settled = (words_since == SETTLE);
                    if (words_since < SETTLE) words_since++;
                    if (descrambler_bypass) exp_data = bus.i_data;
                    else if (settled)       exp_data = cur_payload;
                    else                    exp_data = d;
                    exp_q.push_back({err, settled, bus.i_header_valid, bus.i_header, exp_data});
                end
                if (i_hdr_err_clear) hdr_cnt_model = (acc && err) ? 1 : 0;
                else if (acc && err && (hdr_cnt_model < 65535)) hdr_cnt_model++;
                if (i_flush) begin
                    exp_q.delete();
                    words_since = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [W-1:0] payload, input logic [1:0] hdr,
                             input logic hv, input logic byp, input logic clr);
        logic [W-1:0] sc;
        int waited;
        tx_scramble(payload, sc);
        cur_payload        = payload;
        bus.i_data         = sc;
        bus.i_header       = hdr;
        bus.i_header_valid = hv;
        descrambler_bypass = byp;
        i_hdr_err_clear    = clr;
        bus.i_valid        = 1'b1;
        waited = 0;
        forever begin
            @(negedge i_clk);
            if (bus.o_ready) break;
            waited++;
            if (waited > 200) break;
        end
        n_cmp++;
        if (waited > 200) begin
            n_fail++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", waited);
        end
        @(posedge i_clk);
        #1;
        bus.i_valid        = 1'b0;
        descrambler_bypass = 1'b0;
        i_hdr_err_clear    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic rand_hdr(output logic [1:0] h, output logic hv);
        h  = 2'($urandom_range(0, 3));
        hv = ($urandom_range(0, 3) == 0);
    endtask

    task automatic drain();
        int k;
        ready_rand  = 1'b0;
        ready_fixed = 1'b1;
        k = 0;
        forever begin
            @(posedge i_clk);
            #2;
            k++;
            if ((exp_q.size() == 0) && !bus.o_valid) break;
            if (k > 50) break;
        end
        n_cmp++;
        if (k > 50) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
        end
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge i_clk);
        #1;
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_o_valid: got %b, required 0", bus.o_valid); end
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_o_ready: got %b, required 1", bus.o_ready); end
        n_cmp++; if (bus.o_data !== '0) begin n_fail++; $display("FAIL rst_o_data: got %h, required 0", bus.o_data); end
        n_cmp++; if (bus.o_header !== 2'b00) begin n_fail++; $display("FAIL rst_o_header: got %b, required 00", bus.o_header); end
        n_cmp++; if (bus.o_header_valid !== 1'b0) begin n_fail++; $display("FAIL rst_o_header_valid: got %b, required 0", bus.o_header_valid); end
        n_cmp++; if (bus.o_settled !== 1'b0) begin n_fail++; $display("FAIL rst_o_settled: got %b, required 0", bus.o_settled); end
        n_cmp++; if (bus.o_hdr_err !== 1'b0) begin n_fail++; $display("FAIL rst_o_hdr_err: got %b, required 0", bus.o_hdr_err); end
        n_cmp++; if (o_hdr_err_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", o_hdr_err_count); end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic test_loopback();
        logic [1:0] h;
        logic       hv;
        int         start;
        @(posedge i_clk);
        #1;
        start = cyc;
        for (int i = 0; i < 1000; i++) begin
            rand_hdr(h, hv);
            send_word($urandom(), h, hv, 1'b0, 1'b0);
        end
        n_cmp++;
        if ((cyc - start) != 1000) begin
            n_fail++;
            $display("FAIL throughput: got %0d cycles for 1000 words, required 1000", cyc - start);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [1:0] h;
        logic       hv;
        ready_rand = 1'b1;
        chk_ordy   = 1'b1;
        for (int i = 0; i < 500; i++) begin
            rand_hdr(h, hv);
            send_word($urandom(), h, hv, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        chk_ordy = 1'b0;
        drain();
    endtask

    task automatic test_header();
        logic [1:0] hdrs [5];
        hdrs[0] = 2'b01; hdrs[1] = 2'b10; hdrs[2] = 2'b00; hdrs[3] = 2'b11; hdrs[4] = 2'b11;
        do_reset();
        for (int i = 0; i < 5; i++) send_word($urandom(), hdrs[i], 1'b1, 1'b0, 1'b0);
        send_word($urandom(), 2'b11, 1'b0, 1'b0, 1'b0);
        drain();
        n_cmp++;
        if (o_hdr_err_count !== 16'(hdr_cnt_model)) begin
            n_fail++;
            $display("FAIL hdr_count: got %0d, required %0d", o_hdr_err_count, hdr_cnt_model);
        end
        send_word($urandom(), 2'b00, 1'b1, 1'b0, 1'b1);
        drain();
        n_cmp++;
        if (o_hdr_err_count !== 16'(hdr_cnt_model)) begin
            n_fail++;
            $display("FAIL hdr_clear_count: got %0d, required %0d", o_hdr_err_count, hdr_cnt_model);
        end
        send_word($urandom(), 2'b01, 1'b1, 1'b1, 1'b0);
        send_word($urandom(), 2'b11, 1'b1, 1'b1, 1'b0);
        drain();
        n_cmp++;
        if (o_hdr_err_count !== 16'(hdr_cnt_model)) begin
            n_fail++;
            $display("FAIL hdr_bypass_count: got %0d, required %0d", o_hdr_err_count, hdr_cnt_model);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 8; i++) send_word($urandom(), 2'b01, 1'b1, 1'b0, 1'b0);
        drain();
        ready_fixed = 1'b0;
        idle(1);
        send_word($urandom(), 2'b01, 1'b1, 1'b0, 1'b0);
        send_word($urandom(), 2'b10, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b, required 1", bus.o_valid); end
        n_cmp++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL flush_pre_ready: got %b, required 0", bus.o_ready); end
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_o_valid: got %b, required 0", bus.o_valid); end
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_o_ready: got %b, required 1", bus.o_ready); end
        ready_fixed = 1'b1;
        for (int i = 0; i < 4; i++) send_word($urandom(), 2'b01, 1'b1, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_bypass();
        for (int i = 1; i <= 12; i++) begin
            send_word($urandom(), 2'b10, 1'b1, (i >= 5) && (i <= 8), 1'b0);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        ready_fixed = 1'b0;
        idle(1);
        send_word($urandom(), 2'b11, 1'b1, 1'b0, 1'b0);
        send_word($urandom(), 2'b01, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b, required 1", bus.o_valid); end
        n_cmp++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre_ready: got %b, required 0", bus.o_ready); end
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_o_valid: got %b, required 0", bus.o_valid); end
        n_cmp++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_o_ready: got %b, required 1", bus.o_ready); end
        n_cmp++; if (o_hdr_err_count !== 16'd0) begin n_fail++; $display("FAIL mid_count: got %0d, required 0", o_hdr_err_count); end
        ready_fixed = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) send_word($urandom(), 2'b01, 1'b1, 1'b0, 1'b0);
        drain();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        i_rst              = 1'b1;
        i_flush            = 1'b0;
        descrambler_bypass = 1'b0;
        i_hdr_err_clear    = 1'b0;
        bus.i_valid        = 1'b0;
        bus.i_data         = '0;
        bus.i_header       = 2'b00;
        bus.i_header_valid = 1'b0;
        for (int i = 0; i < 58; i++) tx_hist.push_back(bit'($urandom_range(0, 1)));
        model_reset();

        test_reset();
        test_loopback();
        test_backpressure();
        test_header();
        test_flush();
        test_bypass();
        test_reset_midstream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_descrambler.md
# eth_descrambler

Receive-side self-synchronous descrambler for the 64b/66b PCS, polynomial x^58 + x^39 + 1. Sits after the gearbox/block-lock stage and before the 64b/66b decoder. Restores the payload stream produced by the transmit scrambler, passes 66b sync headers through alongside the data, flags words whose descrambler history is not yet valid, and counts illegal sync headers. Uses a full valid/ready handshake on both sides, with a skid stage so that upstream ready is registered.

## Interface
Parameters:
- DATA_WIDTH, 32, payload word width; legal values are 32 or 64.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high; one clock domain.
- i_flush  in  1  block lock lost; synchronous pulse.
- descrambler_bypass  in  1  when 1, payload passes unchanged.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  upstream may transfer.
- i_data  in  DATA_WIDTH  scrambled payload, MSB transmitted first.
- i_header  in  2  sync header; meaningful only when i_header_valid=1.
- i_header_valid  in  1  beat is the first word of a 66b block.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_WIDTH  descrambled payload.
- o_header  out  2  registered copy of i_header.
- o_header_valid  out  1  registered copy of i_header_valid.
- o_settled  out  1  this word's 58-bit history came entirely from real input.
- o_hdr_err  out  1  one-cycle pulse per accepted beat with i_header_valid=1 and i_header of 00 or 11.
- o_hdr_err_count  out  16  saturating count of illegal headers.
- i_hdr_err_clear  in  1  synchronous clear of o_hdr_err_count.

## Operation
- Accept happens when i_valid && o_ready. Output transfer happens when o_valid && i_ready.
- Descrambler state S[57:0] resets to all ones.
- Per bit, MSB first: out[b] = in[b] ^ S[38] ^ S[57], then S = {S[56:0], in[b]}.
- S shifts in the received (scrambled) bit, never the output bit.
- After each accepted word, S = {S[57-DATA_WIDTH:0], i_data} for DATA_WIDTH=32. For DATA_WIDTH=64, S = i_data[57:0].
- Bypass: o_data = i_data, but S still updates, so descrambling resumes in sync when bypass drops. Bypass is sampled per accepted beat.
- Settle counter: SETTLE_WORDS = ceil(58/DATA_WIDTH), which is 2 for W=32 and 1 for W=64.
  - The counter counts accepted words since reset or flush and saturates at SETTLE_WORDS.
  - o_settled for a word = (count before that word's accept) == SETTLE_WORDS.
- Flush:
  - Clears the settle counter and both pipeline stages (o_valid drops next cycle).
  - Does not reset S.
  - A beat presented in the same cycle as flush is dropped, and o_ready is still honoured.
- Header error:
  - o_hdr_err asserts in the same cycle the offending word becomes o_valid.
  - The counter increments on accept and saturates at 0xFFFF.
  - Clear and increment in the same cycle gives 1.
  - Headers are not checked in bypass mode only if i_header_valid=0; bypass does not suppress checking.

## Timing
- Latency: 1 cycle from accept to o_valid with an empty pipeline.
- Output stage plus one skid register. o_ready = !skid_full, registered, with no combinational i_ready→o_ready path.
- Sustained throughput: 1 word/cycle with i_ready held high.
- When i_ready falls, at most one extra word is captured in the skid. Order is preserved.
- The skid drains before any new accept, and S advances only on accept.
- Reset values:
  - o_valid=0, o_ready=1.
  - o_data, o_header, o_header_valid, o_settled, o_hdr_err all 0.
  - o_hdr_err_count=0, S=all ones, settle count=0.
- Reset asserted mid-stream discards both stages immediately (asynchronously). The first word after release is unsettled.
- Output-side signals are held stable while o_valid && !i_ready.

## Structure
- Shared package eth_pcs_pkg holds:
  - SCR_LEN=58, SCR_TAP_A=38, SCR_TAP_B=57, SCR_INIT='1.
  - SYNC_DATA=2'b01, SYNC_CTRL=2'b10.
  - A function scr_settle_words(width).
- The scrambler is updated to import the same constants.
- Sub-module eth_skid_buffer (parametric payload width) carries the {data, header, header_valid, settled, hdr_err} bundle. The descrambler core stays combinational in front of it, with S and the counters held in the top module.

## Test plan
- Loopback: eth_scrambler → eth_descrambler, 1000 random 32-bit words. From the 3rd word on, output equals the scrambler input and o_settled=1. Words 1–2 have o_settled=0.
- Backpressure: i_ready random at 50%, 500 words. No loss or duplication, order is exact, o_ready never drops for more than 1 consecutive cycle while i_ready=1.
- Header check: accept headers 01, 10, 00, 11, 11 → o_hdr_err pulses on beats 3–5 and count=3. Assert i_hdr_err_clear together with a bad header → count=1.
- Flush: flush after word 10 → the pipeline empties, the next two words have o_settled=0, and the third word decodes correctly with no S reset.
- Bypass: toggle bypass on for words 5–8. Those words are output raw, and words 9+ are descrambled correctly.
- Reset mid-stream: assert i_rst while o_valid=1 and the skid is full → o_valid=0 and o_ready=1 immediately. After release, o_hdr_err_count=0 and the first word is unsettled.
